// File: rtl/ocp_pio_arbiter_pkg.sv
// Shared types and constants for the two-master OCP PIO arbiter in front of the timer register port.
package ocp_pio_pkg;

    localparam int unsigned CMD_W  = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic [CMD_W-1:0] OCP_IDLE  = 4'd0;
    localparam logic [CMD_W-1:0] OCP_READ  = 4'd2;
    localparam logic [CMD_W-1:0] OCP_WRITE = 4'd4;

    localparam logic [ADDR_W-1:0] TIMER_START_ADDR = 32'h4000_0000;
    localparam logic [ADDR_W-1:0] TIMER_CURR_ADDR  = 32'h4000_0004;
    localparam logic [ADDR_W-1:0] TIMER_CTRL_ADDR  = 32'h4000_0008;

    typedef enum logic [1:0] {IDLE, CMD, RESP, DONE} arb_state_t;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ocp_req_t;

    // Legal command, inside the slave window, word aligned.
    function automatic logic req_ok(input ocp_req_t r,
                                    input logic [ADDR_W-1:0] base,
                                    input logic [ADDR_W-1:0] last);
        return ((r.cmd == OCP_READ) || (r.cmd == OCP_WRITE)) &&
               (r.addr >= base) && (r.addr <= last) && (r.addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/ocp_pio_arbiter_if.sv
// Bundle of both master ports and the slave port; the arbiter uses the slave modport.
interface ocp_pio_arbiter_if;
    import ocp_pio_pkg::*;

    logic [CMD_W-1:0]  m0_mcmd, m1_mcmd;
    logic [ADDR_W-1:0] m0_maddr, m1_maddr;
    logic [DATA_W-1:0] m0_mdata, m1_mdata;
    logic              m0_scmdaccept, m1_scmdaccept;
    logic              m0_sresp, m1_sresp;
    logic              m0_serr, m1_serr;
    logic [DATA_W-1:0] m0_sdata, m1_sdata;

    logic [CMD_W-1:0]  s_mcmd;
    logic [ADDR_W-1:0] s_maddr;
    logic [DATA_W-1:0] s_mdata;
    logic              s_scmdaccept, s_sresp;
    logic [DATA_W-1:0] s_sdata;

    modport slave (
        input  m0_mcmd, m1_mcmd, m0_maddr, m1_maddr, m0_mdata, m1_mdata,
        output m0_scmdaccept, m1_scmdaccept, m0_sresp, m1_sresp,
        output m0_serr, m1_serr, m0_sdata, m1_sdata,
        output s_mcmd, s_maddr, s_mdata,
        input  s_scmdaccept, s_sresp, s_sdata
    );

    modport master (
        output m0_mcmd, m1_mcmd, m0_maddr, m1_maddr, m0_mdata, m1_mdata,
        input  m0_scmdaccept, m1_scmdaccept, m0_sresp, m1_sresp,
        input  m0_serr, m1_serr, m0_sdata, m1_sdata,
        input  s_mcmd, s_maddr, s_mdata,
        output s_scmdaccept, s_sresp, s_sdata
    );

endinterface

// File: rtl/ocp_pio_arbiter_rr_arb2.sv
// Two-way round-robin pick; the pointer only moves when both masters contend.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic       grant_c,
    output logic       valid_c
);

    logic last;

    always_comb begin
        grant_c = 1'b0;
        valid_c = |req;
        case (req)
            2'b10:   grant_c = 1'b1;
            2'b11:   grant_c = ~last;
            default: grant_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            last <= 1'b1;
        else if (take && (&req))
            last <= grant_c;
    end

endmodule

// File: rtl/ocp_pio_arbiter.sv
// Shares the timer register port between two OCP masters: round-robin grant, address
// decode, one outstanding command, and a timeout so a bad slave cannot lock the port.
module ocp_pio_arbiter
    import ocp_pio_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_BASE = TIMER_START_ADDR,
    parameter logic [ADDR_W-1:0] ADDR_LAST = TIMER_CTRL_ADDR,
    parameter int unsigned       TIMEOUT   = 16
) (
    input logic               clk,
    input logic               reset_n,
    ocp_pio_arbiter_if.slave  bus
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    arb_state_t        state_q, state_d;
    ocp_req_t          req0, req1, req_q, req_d;
    logic              gnt_q, gnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CMD_W-1:0]  s_cmd_q, s_cmd_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic [1:0]        acc_q, acc_d, rsp_q, rsp_d, err_q, err_d;
    logic [DATA_W-1:0] sdata0_q, sdata0_d, sdata1_q, sdata1_d, rdata_d;
    logic              take, slave_done, tmo;
    logic              arb_grant_c, arb_valid_c;

    assign req0 = '{cmd: bus.m0_mcmd, addr: bus.m0_maddr, data: bus.m0_mdata};
    assign req1 = '{cmd: bus.m1_mcmd, addr: bus.m1_maddr, data: bus.m1_mdata};

    rr_arb2 u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({bus.m1_mcmd != OCP_IDLE, bus.m0_mcmd != OCP_IDLE}),
        .take    (take),
        .grant_c (arb_grant_c),
        .valid_c (arb_valid_c)
    );

    // Next state and next values of every registered output.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        req_d      = req_q;
        cnt_d      = cnt_q;
        s_cmd_d    = s_cmd_q;
        s_addr_d   = s_addr_q;
        s_data_d   = s_data_q;
        acc_d      = '0;
        rsp_d      = '0;
        err_d      = '0;
        rdata_d    = '0;
        take       = 1'b0;
        slave_done = 1'b0;
        tmo        = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_valid_c) begin
                    take             = 1'b1;
                    gnt_d            = arb_grant_c;
                    req_d            = arb_grant_c ? req1 : req0;
                    acc_d[arb_grant_c] = 1'b1;
                    if (req_ok(req_d, ADDR_BASE, ADDR_LAST)) begin
                        state_d  = CMD;
                        s_cmd_d  = req_d.cmd;
                        s_addr_d = req_d.addr;
                        s_data_d = req_d.data;
                        cnt_d    = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            CMD, RESP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (state_q == CMD && bus.s_scmdaccept) begin
                    s_cmd_d    = OCP_IDLE;
                    state_d    = RESP;
                    slave_done = bus.s_sresp;
                end else if (state_q == RESP) begin
                    slave_done = bus.s_sresp;
                end
                // A response on the timeout edge still wins.
                tmo = !slave_done && (cnt_q == CNT_W'(TIMEOUT - 1));
                if (slave_done || tmo) begin
                    state_d      = DONE;
                    s_cmd_d      = OCP_IDLE;
                    rsp_d[gnt_q] = 1'b1;
                    err_d[gnt_q] = tmo;
                    if (slave_done && req_q.cmd == OCP_READ)
                        rdata_d = bus.s_sdata;
                end
            end
            DONE: begin
                // Decode errors arrive here without a response issued yet.
                if (|rsp_q) begin
                    state_d = IDLE;
                end else begin
                    rsp_d[gnt_q] = 1'b1;
                    err_d[gnt_q] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        sdata0_d = rsp_d[0] ? rdata_d : '0;
        sdata1_d = rsp_d[1] ? rdata_d : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            req_q    <= '0;
            cnt_q    <= '0;
            s_cmd_q  <= OCP_IDLE;
            s_addr_q <= '0;
            s_data_q <= '0;
            acc_q    <= '0;
            rsp_q    <= '0;
            err_q    <= '0;
            sdata0_q <= '0;
            sdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            req_q    <= req_d;
            cnt_q    <= cnt_d;
            s_cmd_q  <= s_cmd_d;
            s_addr_q <= s_addr_d;
            s_data_q <= s_data_d;
            acc_q    <= acc_d;
            rsp_q    <= rsp_d;
            err_q    <= err_d;
            sdata0_q <= sdata0_d;
            sdata1_q <= sdata1_d;
        end
    end

    assign bus.m0_scmdaccept = acc_q[0];
    assign bus.m1_scmdaccept = acc_q[1];
    assign bus.m0_sresp      = rsp_q[0];
    assign bus.m1_sresp      = rsp_q[1];
    assign bus.m0_serr       = err_q[0];
    assign bus.m1_serr       = err_q[1];
    assign bus.m0_sdata      = sdata0_q;
    assign bus.m1_sdata      = sdata1_q;
    assign bus.s_mcmd        = s_cmd_q;
    assign bus.s_maddr       = s_addr_q;
    assign bus.s_mdata       = s_data_q;

endmodule
